// File: rtl/eq_serial_cmp_amisha.sv
// Serial equality comparator: walks two latched operands one bit per cycle,
// LSB first, reports equality plus the lowest mismatching bit index, and keeps
// a saturating count of equal results.
module eq_serial_cmp_amisha #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = 8,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic             start_amisha,
    input  logic [WIDTH-1:0] a_amisha,
    input  logic [WIDTH-1:0] b_amisha,
    input  logic             clr_cnt_amisha,
    output logic             busy_amisha,
    output logic             done_amisha,
    output logic             eq_amisha,
    output logic [IDX_W-1:0] idx_amisha,
    output logic [CNT_W-1:0] match_cnt_amisha
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam bit               STOP_ON_MISMATCH = (EARLY_EXIT != 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             acc_q, acc_d;
    logic [IDX_W-1:0] misIdx_q, misIdx_d;
    logic             eq_q, eq_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             bitEq;
    logic             lastBit;
    logic             finish;

    // Bit-level equality of the currently selected operand bit
    always_comb begin
        bitEq   = (~a_q[ptr_q] & ~b_q[ptr_q]) | (a_q[ptr_q] & b_q[ptr_q]);
        lastBit = (ptr_q == LAST_IDX);
    end

    // Next-state logic for the scan FSM, result registers and match counter
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ptr_d    = ptr_q;
        acc_d    = acc_q;
        misIdx_d = misIdx_q;
        eq_d     = eq_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_amisha) begin
                    a_d      = a_amisha;
                    b_d      = b_amisha;
                    ptr_d    = '0;
                    acc_d    = 1'b1;
                    misIdx_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q & bitEq;
                if (acc_q && !bitEq) begin
                    misIdx_d = ptr_q;
                end
                finish = lastBit || (STOP_ON_MISMATCH && !bitEq);
                if (finish) begin
                    state_d = DONE;
                    eq_d    = acc_d;
                    idx_d   = acc_d ? '0 : misIdx_d;
                    if (acc_d && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr_cnt_amisha) begin
            cnt_d = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_amisha) begin
        if (!rst_n_amisha) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ptr_q    <= '0;
            acc_q    <= 1'b0;
            misIdx_q <= '0;
            eq_q     <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ptr_q    <= ptr_d;
            acc_q    <= acc_d;
            misIdx_q <= misIdx_d;
            eq_q     <= eq_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_amisha      = (state_q != IDLE);
    assign done_amisha      = (state_q == DONE);
    assign eq_amisha        = eq_q;
    assign idx_amisha       = idx_q;
    assign match_cnt_amisha = cnt_q;

endmodule

// File: tb/tb_eq_serial_cmp_amisha.sv
// Self-checking bench: three comparator instances (early exit, full scan,
// 2-bit counter) share one stimulus stream and are checked cycle by cycle
// against a bit-loop reference model of the comparison rules.
module tb_eq_serial_cmp_amisha;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstN;
    logic         start;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         busyV [3];
    logic         doneV [3];
    logic         eqV   [3];
    logic [2:0]   idxV  [3];
    logic [7:0]   cntE;
    logic [7:0]   cntF;
    logic [1:0]   cntS;

    int passCount  = 0;
    int totalCount = 0;

    int modelCnt [3];
    int lastEq   [3];
    int lastIdx  [3];
    int eeOf     [3] = '{1, 0, 1};
    int cntMax   [3] = '{255, 255, 3};

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    eq_serial_cmp_amisha #(.WIDTH(W), .EARLY_EXIT(1), .CNT_W(8)) dutEarly (
        .clk_amisha(clk), .rst_n_amisha(rstN), .start_amisha(start),
        .a_amisha(a), .b_amisha(b), .clr_cnt_amisha(clr),
        .busy_amisha(busyV[0]), .done_amisha(doneV[0]), .eq_amisha(eqV[0]),
        .idx_amisha(idxV[0]), .match_cnt_amisha(cntE)
    );

    eq_serial_cmp_amisha #(.WIDTH(W), .EARLY_EXIT(0), .CNT_W(8)) dutFull (
        .clk_amisha(clk), .rst_n_amisha(rstN), .start_amisha(start),
        .a_amisha(a), .b_amisha(b), .clr_cnt_amisha(clr),
        .busy_amisha(busyV[1]), .done_amisha(doneV[1]), .eq_amisha(eqV[1]),
        .idx_amisha(idxV[1]), .match_cnt_amisha(cntF)
    );

    eq_serial_cmp_amisha #(.WIDTH(W), .EARLY_EXIT(1), .CNT_W(2)) dutSat (
        .clk_amisha(clk), .rst_n_amisha(rstN), .start_amisha(start),
        .a_amisha(a), .b_amisha(b), .clr_cnt_amisha(clr),
        .busy_amisha(busyV[2]), .done_amisha(doneV[2]), .eq_amisha(eqV[2]),
        .idx_amisha(idxV[2]), .match_cnt_amisha(cntS)
    );

    function automatic logic [31:0] getCnt(input int k);
        case (k)
            0:       return {24'd0, cntE};
            1:       return {24'd0, cntF};
            default: return {30'd0, cntS};
        endcase
    endfunction

    // Lowest differing bit position, or -1 when the operands are equal
    function automatic int firstDiff(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 0; i < W; i++) begin
            if (x[i] != y[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkResults(input int k, input string when);
        checkOutput($sformatf("eq[%0d]%s", k, when), {31'd0, eqV[k]}, lastEq[k]);
        checkOutput($sformatf("idx[%0d]%s", k, when), {29'd0, idxV[k]}, lastIdx[k]);
        checkOutput($sformatf("cnt[%0d]%s", k, when), getCnt(k), modelCnt[k]);
    endtask

    // One compare: start at edge k, then watch cycles k+1..k+W+2 on every instance
    task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                                 input bit pulseStart, input bit clrAtStart,
                                 input bit clrAtDone, input int resetAt);
        int d;
        int off    [3];
        int expEq  [3];
        int expIdx [3];
        bit interrupted;
        d = firstDiff(opA, opB);
        for (int k = 0; k < 3; k++) begin
            expEq[k]  = (d < 0) ? 1 : 0;
            expIdx[k] = (d < 0) ? 0 : d;
            off[k]    = (eeOf[k] != 0 && d >= 0) ? d + 2 : W + 1;
        end
        rstN  = 1'b1;
        start = 1'b1;
        a     = opA;
        b     = opB;
        clr   = clrAtStart;
        @(posedge clk);
        if (clrAtStart) begin
            for (int k = 0; k < 3; k++) modelCnt[k] = 0;
        end
        for (int c = 1; c <= W + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                clr   = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            if (pulseStart && c == 3) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h00;
            end
            if (pulseStart && c == 4) start = 1'b0;
            if (clrAtDone && c == off[0]) clr = 1'b0;
            if (resetAt != 0 && c == resetAt + 1) begin
                rstN = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    modelCnt[k] = 0;
                    lastEq[k]   = 0;
                    lastIdx[k]  = 0;
                end
            end
            interrupted = (resetAt != 0 && c > resetAt);
            for (int k = 0; k < 3; k++) begin
                if (!interrupted && c == off[k]) begin
                    lastEq[k]  = expEq[k];
                    lastIdx[k] = expIdx[k];
                    if (clrAtDone) modelCnt[k] = 0;
                    else if (expEq[k] == 1 && modelCnt[k] < cntMax[k]) modelCnt[k]++;
                end
                checkOutput($sformatf("busy[%0d]c%0d", k, c), {31'd0, busyV[k]},
                            {31'd0, (!interrupted && c <= off[k])});
                checkOutput($sformatf("done[%0d]c%0d", k, c), {31'd0, doneV[k]},
                            {31'd0, (!interrupted && c == off[k])});
                if (c == 1 || c == off[k] || (resetAt != 0 && c == resetAt + 1)) begin
                    checkResults(k, $sformatf("c%0d", c));
                end
            end
            if (resetAt != 0 && c == resetAt) rstN = 1'b0;
            if (clrAtDone && c == off[0] - 1) clr = 1'b1;
        end
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] one;
        int mode;

        for (int k = 0; k < 3; k++) begin
            modelCnt[k] = 0;
            lastEq[k]   = 0;
            lastIdx[k]  = 0;
        end
        rstN  = 1'b0;
        start = 1'b1;
        clr   = 1'b0;
        a     = 8'h5A;
        b     = 8'h5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rstBusy[%0d]", k), {31'd0, busyV[k]}, 32'd0);
            checkOutput($sformatf("rstDone[%0d]", k), {31'd0, doneV[k]}, 32'd0);
            checkResults(k, "rst");
        end

        applyStimulus(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(8'h77, 8'h77, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 0);

        for (int n = 0; n < 16; n++) begin
            x    = W'($urandom);
            mode = $urandom_range(0, 2);
            one  = 8'h01;
            if (mode == 0) y = x;
            else if (mode == 1) y = x ^ (one << $urandom_range(0, W - 1));
            else y = W'($urandom);
            applyStimulus(x, y, 1'b0, 1'b0, 1'b0, 0);
        end

        applyStimulus(8'hC3, 8'hC3, 1'b0, 1'b1, 1'b0, 0);
        for (int n = 0; n < 4; n++) begin
            x = W'($urandom);
            applyStimulus(x, x, 1'b0, 1'b0, 1'b0, 0);
        end
        applyStimulus(8'hE1, 8'hE1, 1'b0, 1'b0, 1'b1, 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
